// File: rtl/evaluador_condiciones_pkg.sv
// Shared types and pure helpers for the condition evaluator: condition codes,
// FSM states, flag update masks and the condition table.
package paquete_banderas;

  typedef enum logic [3:0] {
    C_EQ = 4'h0, C_NE = 4'h1, C_CS = 4'h2, C_CC = 4'h3,
    C_MI = 4'h4, C_PL = 4'h5, C_VS = 4'h6, C_VC = 4'h7,
    C_HI = 4'h8, C_LS = 4'h9, C_GE = 4'hA, C_LT = 4'hB,
    C_GT = 4'hC, C_LE = 4'hD, C_AL = 4'hE, C_NV = 4'hF
  } cond_e;

  typedef enum logic [1:0] {REPOSO, ESPERA, RESPUESTA} estado_e;

  // Which of {N,Z,C,V} the op selected by seleccion is allowed to write.
  function automatic logic [3:0] mascara(input logic [3:0] sel);
    case (sel)
      4'b0000: return 4'b0110;
      4'b0001: return 4'b1100;
      4'b0010: return 4'b0101;
      default: return 4'b0100;
    endcase
  endfunction

  function automatic logic evaluar_cond(input logic [3:0] c, input logic [3:0] nzcv);
    logic n, z, cy, v;
    {n, z, cy, v} = nzcv;
    case (cond_e'(c))
      C_EQ: return z;
      C_NE: return !z;
      C_CS: return cy;
      C_CC: return !cy;
      C_MI: return n;
      C_PL: return !n;
      C_VS: return v;
      C_VC: return !v;
      C_HI: return cy && !z;
      C_LS: return !cy || z;
      C_GE: return n == v;
      C_LT: return n != v;
      C_GT: return !z && (n == v);
      C_LE: return z || (n != v);
      C_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/evaluador_condiciones_contador_vuelo.sv
// Count of ALU ops issued whose flags have not yet arrived; saturates at
// MAX_VUELO and flags (sticky) any flag delivery with nothing in flight.
module contador_vuelo #(
  parameter int MAX_VUELO = 3,
  localparam int W = $clog2(MAX_VUELO + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         emitir,
  input  logic         flags_valid,
  output logic         ready,
  output logic [W-1:0] count_next,
  output logic         underflow
);

  logic [W-1:0] count;
  logic         vacio;

  always_comb begin
    vacio      = (count == '0);
    ready      = (count < W'(MAX_VUELO));
    count_next = count + W'(emitir && ready) - W'(flags_valid && !vacio);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      count <= count_next;
      if (flags_valid && vacio) underflow <= 1'b1;
    end
  end

endmodule

// File: rtl/evaluador_condiciones.sv
// Architectural NZCV register plus a condition-query engine that holds each
// query until every in-flight ALU op has delivered its flags (or times out).
module evaluador_condiciones
  import paquete_banderas::*;
#(
  parameter int ancho     = 3,
  parameter int MAX_VUELO = 3,
  parameter int TIMEOUT   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alu_emitir,
  output logic       alu_emitir_ready,
  input  logic       flags_valid,
  input  logic [3:0] seleccion,
  input  logic       N,
  input  logic       Z,
  input  logic       C,
  input  logic       V,
  input  logic       cond_valid,
  input  logic [3:0] cond,
  output logic       cond_ready,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_cond,
  output logic       error_timeout,
  output logic       error_underflow,
  output logic [3:0] banderas
);

  localparam int CW = $clog2(MAX_VUELO + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  estado_e       estado;
  logic [3:0]    cond_q;
  logic [TW-1:0] timer;
  logic [3:0]    banderas_next, mask;
  logic [CW-1:0] count_next;
  logic          nada_pendiente;

  contador_vuelo #(.MAX_VUELO(MAX_VUELO)) u_contador (
    .clk        (clk),
    .rst        (rst),
    .emitir     (alu_emitir),
    .flags_valid(flags_valid),
    .ready      (alu_emitir_ready),
    .count_next (count_next),
    .underflow  (error_underflow)
  );

  // Evaluating against next-state flags lets a delivery on the deciding edge count.
  always_comb begin
    mask           = mascara(seleccion);
    banderas_next  = flags_valid ? ((mask & {N, Z, C, V}) | (~mask & banderas)) : banderas;
    nada_pendiente = (count_next == '0);
  end

  assign cond_ready = (estado == REPOSO);

  always_ff @(posedge clk) begin
    if (rst) begin
      estado        <= REPOSO;
      banderas      <= '0;
      cond_q        <= '0;
      timer         <= '0;
      res_valid     <= 1'b0;
      res_cond      <= 1'b0;
      error_timeout <= 1'b0;
    end else begin
      banderas <= banderas_next;
      case (estado)
        REPOSO: if (cond_valid) begin
          cond_q <= cond;
          timer  <= '0;
          if (nada_pendiente) begin
            estado    <= RESPUESTA;
            res_valid <= 1'b1;
            res_cond  <= evaluar_cond(cond, banderas_next);
          end else begin
            estado <= ESPERA;
          end
        end
        ESPERA: begin
          if (nada_pendiente) begin
            estado    <= RESPUESTA;
            res_valid <= 1'b1;
            res_cond  <= evaluar_cond(cond_q, banderas_next);
          end else if (timer == TW'(TIMEOUT - 1)) begin
            estado        <= RESPUESTA;
            res_valid     <= 1'b1;
            res_cond      <= 1'b0;
            error_timeout <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESPUESTA: if (res_ready) begin
          estado        <= REPOSO;
          res_valid     <= 1'b0;
          error_timeout <= 1'b0;
        end
        default: estado <= REPOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_evaluador_condiciones.sv
// Directed bench for evaluador_condiciones with hand-computed expectations.
module tb_evaluador_condiciones;

  logic       clk = 1'b0;
  logic       rst;
  logic       alu_emitir, alu_emitir_ready;
  logic       flags_valid;
  logic [3:0] seleccion;
  logic       N, Z, C, V;
  logic       cond_valid, cond_ready;
  logic [3:0] cond;
  logic       res_valid, res_ready, res_cond;
  logic       error_timeout, error_underflow;
  logic [3:0] banderas;

  int checks = 0;
  int failures = 0;

  evaluador_condiciones #(.ancho(3), .MAX_VUELO(3), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .alu_emitir(alu_emitir), .alu_emitir_ready(alu_emitir_ready),
    .flags_valid(flags_valid), .seleccion(seleccion),
    .N(N), .Z(Z), .C(C), .V(V),
    .cond_valid(cond_valid), .cond(cond), .cond_ready(cond_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_cond(res_cond),
    .error_timeout(error_timeout), .error_underflow(error_underflow),
    .banderas(banderas)
  );

  always #5 clk = ~clk;

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [3:0] sel, input logic [3:0] nzcv);
    flags_valid = 1'b1;
    seleccion   = sel;
    {N, Z, C, V} = nzcv;
  endtask

  // Query with nothing in flight: response must be present right after acceptance.
  task automatic query_now(input string tag, input logic [3:0] c, input logic exp);
    cond_valid = 1'b1; cond = c;
    step();
    cond_valid = 1'b0;
    comprobar({tag, "_valid"}, res_valid, 1'b1);
    comprobar({tag, "_cond"}, res_cond, exp);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    comprobar({tag, "_done"}, res_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1; alu_emitir = 0; flags_valid = 0; seleccion = 0;
    {N, Z, C, V} = 4'b0; cond_valid = 0; cond = 0; res_ready = 0;
    step(); step();
    rst = 1'b0;
    comprobar("rst_banderas", banderas, 4'b0000);
    comprobar("rst_res_valid", res_valid, 1'b0);
    comprobar("rst_cond_ready", cond_ready, 1'b1);
    comprobar("rst_emit_ready", alu_emitir_ready, 1'b1);
    comprobar("rst_err_to", error_timeout, 1'b0);
    comprobar("rst_err_uf", error_underflow, 1'b0);

    query_now("eq_after_rst", 4'h0, 1'b0);

    // One op in flight; HI query waits, flags arrive a cycle later.
    alu_emitir = 1; step(); alu_emitir = 0;
    cond_valid = 1; cond = 4'h8; step(); cond_valid = 0;
    comprobar("hi_waiting", res_valid, 1'b0);
    comprobar("hi_busy", cond_ready, 1'b0);
    set_flags(4'b0000, 4'b1110); step(); flags_valid = 0;
    comprobar("hi_valid", res_valid, 1'b1);
    comprobar("hi_cond", res_cond, 1'b0);
    comprobar("hi_banderas", banderas, 4'b0110);
    res_ready = 1; step(); res_ready = 0;
    comprobar("hi_done", res_valid, 1'b0);

    query_now("ls", 4'h9, 1'b1);
    query_now("ge", 4'hA, 1'b1);
    query_now("cc", 4'h3, 1'b0);

    // Flags arriving on the acceptance edge are part of the evaluation.
    alu_emitir = 1; step(); alu_emitir = 0;
    set_flags(4'b0001, 4'b1000);
    cond_valid = 1; cond = 4'h4; step();
    cond_valid = 0; flags_valid = 0;
    comprobar("mi_same_edge_valid", res_valid, 1'b1);
    comprobar("mi_same_edge_cond", res_cond, 1'b1);
    comprobar("mi_banderas", banderas, 4'b1010);
    res_ready = 1; step(); res_ready = 0;

    query_now("lt", 4'hB, 1'b1);
    query_now("gt", 4'hC, 1'b0);
    query_now("nv", 4'hF, 1'b0);
    query_now("al", 4'hE, 1'b1);

    // Timeout: AL would be true, so res_cond=0 shows the forced error response.
    alu_emitir = 1; step(); alu_emitir = 0;
    cond_valid = 1; cond = 4'hE; step(); cond_valid = 0;
    for (int i = 0; i < 7; i++) step();
    comprobar("to_not_yet", res_valid, 1'b0);
    step();
    comprobar("to_valid", res_valid, 1'b1);
    comprobar("to_cond", res_cond, 1'b0);
    comprobar("to_err", error_timeout, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      comprobar("hold_valid", res_valid, 1'b1);
      comprobar("hold_cond", res_cond, 1'b0);
      comprobar("hold_err", error_timeout, 1'b1);
      comprobar("hold_busy", cond_ready, 1'b0);
    end
    res_ready = 1; step(); res_ready = 0;
    comprobar("to_done_valid", res_valid, 1'b0);
    comprobar("to_done_err", error_timeout, 1'b0);
    comprobar("to_done_ready", cond_ready, 1'b1);

    // One op left from the timeout; fill to 3.
    alu_emitir = 1; step();
    comprobar("cnt2_ready", alu_emitir_ready, 1'b1);
    step();
    comprobar("cnt3_full", alu_emitir_ready, 1'b0);
    step();
    comprobar("cnt3_ignored", alu_emitir_ready, 1'b0);
    alu_emitir = 0; set_flags(4'b0010, 4'b1001); step();
    comprobar("cnt_dec_ready", alu_emitir_ready, 1'b1);
    alu_emitir = 1; step();
    flags_valid = 0;
    comprobar("cnt_both_ready", alu_emitir_ready, 1'b1);
    comprobar("sel2_banderas", banderas, 4'b1011);
    step(); alu_emitir = 0;
    comprobar("cnt_refill_full", alu_emitir_ready, 1'b0);
    set_flags(4'b0010, 4'b0100);
    step(); step(); step();
    flags_valid = 0;
    comprobar("drain_banderas", banderas, 4'b1110);
    comprobar("drain_no_uf", error_underflow, 1'b0);
    query_now("le", 4'hD, 1'b1);

    // Underflow is sticky.
    set_flags(4'b0011, 4'b0000); step(); flags_valid = 0;
    comprobar("uf_set", error_underflow, 1'b1);
    comprobar("uf_banderas", banderas, 4'b1010);
    step();
    comprobar("uf_sticky", error_underflow, 1'b1);

    // Reset while a query waits in ESPERA drops it.
    alu_emitir = 1; step(); alu_emitir = 0;
    cond_valid = 1; cond = 4'h1; step(); cond_valid = 0;
    comprobar("pre_rst_busy", cond_ready, 1'b0);
    rst = 1; step(); rst = 0;
    comprobar("mid_rst_ready", cond_ready, 1'b1);
    comprobar("mid_rst_valid", res_valid, 1'b0);
    comprobar("mid_rst_banderas", banderas, 4'b0000);
    comprobar("mid_rst_uf", error_underflow, 1'b0);
    step(); step();
    comprobar("mid_rst_no_resp", res_valid, 1'b0);
    query_now("ne_after_rst", 4'h1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
